// File: rtl/pipeline_debug_dumper_if.sv
// Byte-stream handshake between the debug dumper and the serial transmitter.
// The master offers tx_data/tx_valid; the slave answers with tx_ready.
interface pipeline_debug_dumper_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/pipeline_debug_dumper.sv
// Captures NUM_WORDS pipeline words, freezes the pipeline and streams a framed
// dump: HEADER, count, data (word 0 first, MSB first), XOR checksum. Define DEBUG_STEP_EN for single-step.
module pipeline_debug_dumper #(
    parameter int unsigned NUM_WORDS = 8,
    parameter logic [7:0]  HEADER    = 8'hA5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      dump_req,
    input  logic [32*NUM_WORDS-1:0]   snapshot_in,
`ifdef DEBUG_STEP_EN
    input  logic                      step_mode,
    input  logic                      step_req,
`endif
    pipeline_debug_dumper_if.master   tx,
    output logic                      pipe_enable,
    output logic                      busy,
    output logic                      dump_done
);

    localparam logic [7:0] COUNT_BYTE = 8'(NUM_WORDS);
    localparam logic [7:0] LAST_WORD  = 8'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_COUNT,
        S_DATA,
        S_CHECKSUM,
        S_DONE,
        S_STEP,
        S_SETTLE
    } state_t;

    state_t                    state_q, state_d;
    logic [7:0]                tx_data_q, tx_data_d;
    logic                      tx_valid_q, tx_valid_d;
    logic                      pipe_enable_q, pipe_enable_d;
    logic                      busy_q, busy_d;
    logic                      dump_done_q, dump_done_d;
    logic [32*NUM_WORDS-1:0]   snap_q, snap_d;
    logic [7:0]                word_idx_q, word_idx_d;
    logic [1:0]                byte_idx_q, byte_idx_d;
    logic [7:0]                csum_q, csum_d;

    logic                      xfer;
    logic                      start_dump;
    logic                      idle_pe;
    logic [31:0]               cur_word;
    logic [31:0]               next_word;
    logic [7:0]                csum_acc;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] b);
        case (b)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    // Mux by compare so the word index width never has to match the array depth.
    function automatic logic [31:0] word_of(input logic [32*NUM_WORDS-1:0] v,
                                            input logic [7:0] idx);
        logic [31:0] w;
        w = '0;
        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            if (idx == 8'(i)) w = v[i*32 +: 32];
        end
        return w;
    endfunction

`ifdef DEBUG_STEP_EN
    assign idle_pe = ~step_mode;
`else
    assign idle_pe = 1'b1;
`endif

    assign xfer      = tx_valid_q & tx.tx_ready;
    assign cur_word  = word_of(snap_q, word_idx_q);
    assign next_word = word_of(snap_q, word_idx_q + 8'd1);
    assign csum_acc  = csum_q ^ tx_data_q;

    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        pipe_enable_d = pipe_enable_q;
        busy_d        = busy_q;
        dump_done_d   = 1'b0;
        snap_d        = snap_q;
        word_idx_d    = word_idx_q;
        byte_idx_d    = byte_idx_q;
        csum_d        = csum_q;
        start_dump    = 1'b0;

        case (state_q)
            S_IDLE: begin
                pipe_enable_d = idle_pe;
                busy_d        = 1'b0;
                if (dump_req) begin
                    start_dump = 1'b1;
                end
`ifdef DEBUG_STEP_EN
                else if (step_mode && step_req) begin
                    pipe_enable_d = 1'b1;
                    busy_d        = 1'b1;
                    state_d       = S_STEP;
                end
`endif
            end
`ifdef DEBUG_STEP_EN
            // The enable cycle advances the pipeline; the settle cycle lets the
            // post-step values reach snapshot_in before they are captured.
            S_STEP: begin
                pipe_enable_d = 1'b0;
                state_d       = S_SETTLE;
            end
            S_SETTLE: begin
                start_dump = 1'b1;
            end
`endif
            S_HEADER: begin
                if (xfer) begin
                    tx_data_d = COUNT_BYTE;
                    state_d   = S_COUNT;
                end
            end
            S_COUNT: begin
                if (xfer) begin
                    csum_d     = csum_acc;
                    tx_data_d  = byte_of(word_of(snap_q, 8'd0), 2'd0);
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    csum_d = csum_acc;
                    if (byte_idx_q == 2'd3 && word_idx_q == LAST_WORD) begin
                        tx_data_d = csum_acc;
                        state_d   = S_CHECKSUM;
                    end else if (byte_idx_q == 2'd3) begin
                        word_idx_d = word_idx_q + 8'd1;
                        byte_idx_d = '0;
                        tx_data_d  = byte_of(next_word, 2'd0);
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        tx_data_d  = byte_of(cur_word, byte_idx_q + 2'd1);
                    end
                end
            end
            S_CHECKSUM: begin
                if (xfer) begin
                    tx_valid_d  = 1'b0;
                    dump_done_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                pipe_enable_d = idle_pe;
                busy_d        = 1'b0;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start_dump) begin
            snap_d        = snapshot_in;
            pipe_enable_d = 1'b0;
            busy_d        = 1'b1;
            csum_d        = '0;
            word_idx_d    = '0;
            byte_idx_d    = '0;
            tx_data_d     = HEADER;
            tx_valid_d    = 1'b1;
            state_d       = S_HEADER;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            pipe_enable_q <= 1'b1;
            busy_q        <= 1'b0;
            dump_done_q   <= 1'b0;
            snap_q        <= '0;
            word_idx_q    <= '0;
            byte_idx_q    <= '0;
            csum_q        <= '0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            pipe_enable_q <= pipe_enable_d;
            busy_q        <= busy_d;
            dump_done_q   <= dump_done_d;
            snap_q        <= snap_d;
            word_idx_q    <= word_idx_d;
            byte_idx_q    <= byte_idx_d;
            csum_q        <= csum_d;
        end
    end

    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;
    assign pipe_enable = pipe_enable_q;
    assign busy        = busy_q;
    assign dump_done   = dump_done_q;

endmodule

// File: tb/tb_pipeline_debug_dumper.sv
// Bench for pipeline_debug_dumper: a 2-word instance with driven backpressure and
// a 1-word instance with tx_ready tied high, checked against a frame model.
module tb_pipeline_debug_dumper;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        logic [63:0] snap;
        int          period;
        logic [7:0]  cs2;
        logic [7:0]  cs1;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        dump_req;
    logic [63:0] snap;
    logic        ready2;
    logic        pe2, busy2, done2;
    logic        pe1, busy1, done1;
`ifdef DEBUG_STEP_EN
    logic        step_mode;
    logic        step_req;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] q2[$];
    int         t2[$];
    logic [7:0] q1[$];
    int cyc       = 0;
    int done2_cnt = 0;
    int done2_cyc = 0;
    int done1_cnt = 0;
    int pe_bad    = 0;
    int stall_bad = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    pipeline_debug_dumper_if if2();
    pipeline_debug_dumper_if if1();
    assign if2.tx_ready = ready2;
    assign if1.tx_ready = 1'b1;

    pipeline_debug_dumper #(.NUM_WORDS(2), .HEADER(8'hA5)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .dump_req    (dump_req),
        .snapshot_in (snap),
`ifdef DEBUG_STEP_EN
        .step_mode   (step_mode),
        .step_req    (step_req),
`endif
        .tx          (if2),
        .pipe_enable (pe2),
        .busy        (busy2),
        .dump_done   (done2)
    );

    pipeline_debug_dumper #(.NUM_WORDS(1), .HEADER(8'hA5)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .dump_req    (dump_req),
        .snapshot_in (snap[31:0]),
`ifdef DEBUG_STEP_EN
        .step_mode   (step_mode),
        .step_req    (step_req),
`endif
        .tx          (if1),
        .pipe_enable (pe1),
        .busy        (busy1),
        .dump_done   (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observes the pre-edge state: valid&&ready here means a transfer at the next rising edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (if2.tx_valid && if2.tx_ready) begin
            q2.push_back(if2.tx_data);
            t2.push_back(cyc);
        end
        if (if1.tx_valid && if1.tx_ready) q1.push_back(if1.tx_data);
        if (done2) begin
            done2_cnt <= done2_cnt + 1;
            done2_cyc <= cyc;
        end
        if (done1) done1_cnt <= done1_cnt + 1;
        if (if2.tx_valid && pe2) pe_bad <= pe_bad + 1;
        if (rst_n && prev_valid && !prev_ready &&
            (!if2.tx_valid || if2.tx_data != prev_data)) stall_bad <= stall_bad + 1;
        prev_valid <= if2.tx_valid;
        prev_ready <= if2.tx_ready;
        prev_data  <= if2.tx_data;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame = header, word count, every word MSB first, XOR of count and data bytes.
    function automatic byte_q_t build_frame(input logic [63:0] s, input int nw);
        byte_q_t    f;
        logic [7:0] cs;
        logic [31:0] w;
        f.push_back(8'hA5);
        f.push_back(8'(nw));
        cs = 8'(nw);
        for (int i = 0; i < nw; i++) begin
            w = s[i*32 +: 32];
            for (int b = 3; b >= 0; b--) begin
                f.push_back(w[b*8 +: 8]);
                cs = cs ^ w[b*8 +: 8];
            end
        end
        f.push_back(cs);
        return f;
    endfunction

    function automatic byte_q_t grab(input int which, input int start);
        byte_q_t g;
        if (which == 2) begin
            for (int i = start; i < q2.size(); i++) g.push_back(q2[i]);
        end else begin
            for (int i = start; i < q1.size(); i++) g.push_back(q1[i]);
        end
        return g;
    endfunction

    task automatic cmp_frame(input string tag, input byte_q_t got, input byte_q_t exp);
        chk({tag, " frame length"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size()) chk($sformatf("%s byte %0d", tag, i), got[i], exp[i]);
        end
    endtask

    task automatic wait_done2(input int d0, input int period);
        int cnt;
        cnt = 0;
        while (done2_cnt == d0 && cnt < 400) begin
            @(posedge clk); #1;
            if (period == 0) ready2 = ($urandom_range(0, 2) != 0);
            else             ready2 = ((cnt % period) == 0);
            cnt++;
        end
        ready2 = 1'b1;
    endtask

    task automatic run_frame(input string tag, input logic [63:0] s, input int period,
                             input logic [7:0] cs2, input logic [7:0] cs1);
        int      b2, b1, d2, d1, pb, sb;
        byte_q_t g2, g1;
        @(posedge clk); #1;
        snap = s; ready2 = 1'b1; dump_req = 1'b1;
        b2 = q2.size(); b1 = q1.size();
        d2 = done2_cnt; d1 = done1_cnt; pb = pe_bad; sb = stall_bad;
        @(posedge clk); #1;
        dump_req = 1'b0;
        snap = '1;
        chk({tag, " pe frozen after request"}, pe2, 0);
        chk({tag, " busy after request"}, busy2, 1);
        chk({tag, " header offered"}, if2.tx_data, 8'hA5);
        wait_done2(d2, period);
        chk({tag, " pe back in idle"}, pe2, 1);
        chk({tag, " busy clear in idle"}, busy2, 0);
        g2 = grab(2, b2);
        g1 = grab(1, b1);
        cmp_frame({tag, " nw2"}, g2, build_frame(s, 2));
        cmp_frame({tag, " nw1"}, g1, build_frame(s, 1));
        if (g2.size() == 11) chk({tag, " nw2 checksum"}, g2[10], cs2);
        if (g1.size() == 7)  chk({tag, " nw1 checksum"}, g1[6], cs1);
        chk({tag, " nw2 done pulses"}, done2_cnt - d2, 1);
        chk({tag, " nw1 done pulses"}, done1_cnt - d1, 1);
        chk({tag, " pe during frame"}, pe_bad - pb, 0);
        chk({tag, " stall stability"}, stall_bad - sb, 0);
        if (t2.size() >= b2 + 11) begin
            chk({tag, " done after checksum"}, done2_cyc, t2[b2+10] + 1);
            if (period == 1) chk({tag, " back-to-back span"}, t2[b2+10] - t2[b2], 10);
        end
    endtask

    vec_t vecs[5];

    initial begin
        int      b2, d2, cnt;
        byte_q_t g2, e2;
        logic [63:0] s;

        vecs[0] = '{64'hDEADBEEF_12345678, 1, 8'h28, 8'h09};
        vecs[1] = '{64'hDEADBEEF_12345678, 3, 8'h28, 8'h09};
        vecs[2] = '{64'h00000000_00000000, 1, 8'h02, 8'h01};
        vecs[3] = '{64'h00000000_000000FF, 2, 8'hFD, 8'hFE};
        vecs[4] = '{64'h01020304_00000000, 1, 8'h06, 8'h01};

        rst_n = 1'b0; dump_req = 1'b0; snap = '0; ready2 = 1'b1;
`ifdef DEBUG_STEP_EN
        step_mode = 1'b0; step_req = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        chk("reset tx_valid", if2.tx_valid, 0);
        chk("reset tx_data", if2.tx_data, 0);
        chk("reset pipe_enable", pe2, 1);
        chk("reset busy", busy2, 0);
        chk("reset dump_done", done2, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (vecs[i])
            run_frame($sformatf("vec%0d", i), vecs[i].snap, vecs[i].period, vecs[i].cs2, vecs[i].cs1);

        // dump_req held through a frame: one frame, one enabled idle cycle, then the next.
        s = vecs[0].snap;
        @(posedge clk); #1;
        snap = s; dump_req = 1'b1; ready2 = 1'b1;
        b2 = q2.size(); d2 = done2_cnt;
        cnt = 0;
        while (done2_cnt == d2 && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("held req first done", done2_cnt - d2, 1);
        chk("held req idle pe", pe2, 1);
        chk("held req idle busy", busy2, 0);
        chk("held req idle valid", if2.tx_valid, 0);
        chk("held req first frame bytes", q2.size() - b2, 11);
        @(posedge clk); #1;
        chk("held req restart pe", pe2, 0);
        chk("held req restart busy", busy2, 1);
        chk("held req restart header", if2.tx_data, 8'hA5);
        dump_req = 1'b0;
        snap = '1;
        wait_done2(d2 + 1, 1);
        g2 = grab(2, b2);
        e2 = build_frame(s, 2);
        e2 = {e2, e2};
        cmp_frame("held req two frames", g2, e2);

        // Reset in the middle of a frame.
        @(posedge clk); #1;
        snap = vecs[0].snap; dump_req = 1'b1;
        b2 = q2.size();
        @(posedge clk); #1;
        dump_req = 1'b0;
        cnt = 0;
        while (q2.size() - b2 < 5 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("midframe reached byte 5", (q2.size() - b2 >= 5) ? 1 : 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset tx_valid", if2.tx_valid, 0);
        chk("async reset pipe_enable", pe2, 1);
        chk("async reset busy", busy2, 0);
        chk("async reset tx_data", if2.tx_data, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("no resume after reset", if2.tx_valid, 0);
        run_frame("after reset", vecs[0].snap, 1, 8'h28, 8'h09);

        for (int n = 0; n < 20; n++) begin
            s = {$urandom, $urandom};
            e2 = build_frame(s, 2);
            g2 = build_frame(s, 1);
            run_frame($sformatf("rand%0d", n), s, (n % 2 == 0) ? 0 : 1 + (n % 3),
                      e2[10], g2[6]);
        end

`ifdef DEBUG_STEP_EN
        s = 64'hCAFEF00D_0BADBEEF;
        @(posedge clk); #1;
        step_mode = 1'b1; snap = s;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("step idle pe held low", pe2, 0);
        chk("step idle busy", busy2, 0);
        b2 = q2.size(); d2 = done2_cnt;
        step_req = 1'b1;
        @(posedge clk); #1;
        step_req = 1'b0;
        chk("step enable cycle", pe2, 1);
        @(posedge clk); #1;
        chk("step enable one cycle", pe2, 0);
        chk("step settle no frame yet", if2.tx_valid, 0);
        @(posedge clk); #1;
        chk("step auto header", if2.tx_data, 8'hA5);
        chk("step auto valid", if2.tx_valid, 1);
        snap = '1;
        wait_done2(d2, 1);
        cmp_frame("step frame", grab(2, b2), build_frame(s, 2));
        chk("step idle pe after frame", pe2, 0);
        chk("step idle busy after frame", busy2, 0);
        step_mode = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
